// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 timing constants and the 3-bit colour type used by
// vga_timing_gen and the draw_* blocks.
//   VGA_H_* / VGA_V_* : visible, front porch, sync, back porch and total counts
//   rgb_t             : 3-bit colour, bit 2 = red, bit 1 = green, bit 0 = blue
//   RGB_*             : named colours
//   fits_width()      : 1 when a non-negative value is representable in 'width' bits
package vga_pkg;

    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;
    localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    typedef logic [2:0] rgb_t;

    localparam rgb_t RGB_BLACK   = 3'b000;
    localparam rgb_t RGB_BLUE    = 3'b001;
    localparam rgb_t RGB_GREEN   = 3'b010;
    localparam rgb_t RGB_CYAN    = 3'b011;
    localparam rgb_t RGB_RED     = 3'b100;
    localparam rgb_t RGB_MAGENTA = 3'b101;
    localparam rgb_t RGB_YELLOW  = 3'b110;
    localparam rgb_t RGB_WHITE   = 3'b111;

    function automatic bit fits_width(input int value, input int width);
        return (width >= 31) || (value < (1 << width));
    endfunction

endpackage

// File: rtl/vga_timing_gen_wrap_counter.sv
// wrap_counter: enable-qualified up-counter that wraps from MAX back to 0.
//   clk, rst_n : clock and asynchronous active-low reset (count returns to 0)
//   en         : advance the count by one on this clock
//   count_o    : current count, WIDTH bits
//   wrap_out   : 1 when en is high and the count is at MAX (wraps on this clock)
module wrap_counter #(
    parameter int WIDTH = 10,
    parameter int MAX   = 799
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] count_o,
    output logic             wrap_out
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             at_max;

    assign at_max = (count_q == MAX_V);

    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = at_max ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o  = count_q;
    assign wrap_out = en && at_max;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA horizontal/vertical timing from a pixel-rate enable.
//   clk, rst_n     : clock and asynchronous active-low reset
//   pix_en         : pixel strobe; all state advances only when high
//   x_pos, y_pos   : raw horizontal/vertical counters (include blanking values)
//   display_active : x_pos/y_pos inside the visible area (combinational)
//   line_start     : pix_en-qualified pulse at x_pos==0
//   frame_start    : pix_en-qualified pulse at x_pos==0, y_pos==0
//   rgb_in         : colour computed by the drawers from this cycle's x_pos/y_pos
//   rgb_out        : registered colour, blanked outside the visible area
//   hsync, vsync   : registered syncs, polarity chosen by SYNC_NEG
// rgb_out, hsync and vsync are all registered from the same pre-increment
// counter values, so the three pins describe the same pixel one clock later.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int BIT       = 10,
    parameter int H_VISIBLE = VGA_H_VISIBLE,
    parameter int H_FRONT   = VGA_H_FRONT,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BACK    = VGA_H_BACK,
    parameter int V_VISIBLE = VGA_V_VISIBLE,
    parameter int V_FRONT   = VGA_V_FRONT,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BACK    = VGA_V_BACK,
    parameter bit SYNC_NEG  = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           pix_en,
    output logic [BIT-1:0] x_pos,
    output logic [BIT-1:0] y_pos,
    output logic           display_active,
    output logic           line_start,
    output logic           frame_start,
    input  rgb_t           rgb_in,
    output rgb_t           rgb_out,
    output logic           hsync,
    output logic           vsync
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [BIT-1:0] H_VIS_B   = BIT'(H_VISIBLE);
    localparam logic [BIT-1:0] H_SYNC_LO = BIT'(H_VISIBLE + H_FRONT);
    localparam logic [BIT-1:0] H_SYNC_HI = BIT'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [BIT-1:0] V_VIS_B   = BIT'(V_VISIBLE);
    localparam logic [BIT-1:0] V_SYNC_LO = BIT'(V_VISIBLE + V_FRONT);
    localparam logic [BIT-1:0] V_SYNC_HI = BIT'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    // Counters are BIT wide; a total that does not fit would silently alias.
    if (!fits_width(H_TOTAL - 1, BIT)) begin : g_h_width_check
        $error("vga_timing_gen: H_TOTAL-1 (%0d) does not fit in BIT=%0d", H_TOTAL - 1, BIT);
    end
    if (!fits_width(V_TOTAL - 1, BIT)) begin : g_v_width_check
        $error("vga_timing_gen: V_TOTAL-1 (%0d) does not fit in BIT=%0d", V_TOTAL - 1, BIT);
    end

    logic [BIT-1:0] h_cnt;
    logic [BIT-1:0] v_cnt;
    logic           h_wrap;
    logic           v_wrap_unused;

    wrap_counter #(
        .WIDTH (BIT),
        .MAX   (H_TOTAL - 1)
    ) u_h_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (pix_en),
        .count_o  (h_cnt),
        .wrap_out (h_wrap)
    );

    wrap_counter #(
        .WIDTH (BIT),
        .MAX   (V_TOTAL - 1)
    ) u_v_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (pix_en & h_wrap),
        .count_o  (v_cnt),
        .wrap_out (v_wrap_unused)
    );

    logic h_sync_act;
    logic v_sync_act;

    assign h_sync_act = (h_cnt >= H_SYNC_LO) && (h_cnt <= H_SYNC_HI);
    assign v_sync_act = (v_cnt >= V_SYNC_LO) && (v_cnt <= V_SYNC_HI);

    assign x_pos          = h_cnt;
    assign y_pos          = v_cnt;
    assign display_active = (h_cnt < H_VIS_B) && (v_cnt < V_VIS_B);
    assign line_start     = pix_en && (h_cnt == '0);
    assign frame_start    = line_start && (v_cnt == '0);

    // Output pipeline stage: idle level of a sync pin equals SYNC_NEG.
    rgb_t rgb_q;
    rgb_t rgb_d;
    logic hsync_q;
    logic hsync_d;
    logic vsync_q;
    logic vsync_d;

    always_comb begin
        rgb_d   = rgb_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        if (pix_en) begin
            rgb_d   = display_active ? rgb_in : RGB_BLACK;
            hsync_d = h_sync_act ? ~SYNC_NEG : SYNC_NEG;
            vsync_d = v_sync_act ? ~SYNC_NEG : SYNC_NEG;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q   <= RGB_BLACK;
            hsync_q <= SYNC_NEG;
            vsync_q <= SYNC_NEG;
        end else begin
            rgb_q   <= rgb_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign rgb_out = rgb_q;
    assign hsync   = hsync_q;
    assign vsync   = vsync_q;

endmodule
